// File: rtl/keyboard_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// keyboard_arbiter_pkg
// Shared definitions for the keyboard arbiter:
//   - state_t      : arbiter FSM state encoding (IDLE / PLAY / GAP)
//   - KEY_IDX_W    : width of a note index
//   - HALFPER_W    : width of a half-period value in clock cycles
//   - NOTE_HALFPER : base half-period per note (C4..C5 at a 25 kHz clock)
//   - note_halfper : table lookup helper
// -----------------------------------------------------------------------------
package keyboard_arbiter_pkg;

    localparam int KEY_IDX_W = 3;
    localparam int HALFPER_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // C4, D4, E4, F4, G4, A4, B4, C5
    localparam logic [HALFPER_W-1:0] NOTE_HALFPER [8] = '{
        8'd47, 8'd42, 8'd37, 8'd35, 8'd31, 8'd28, 8'd25, 8'd23
    };

    function automatic logic [HALFPER_W-1:0] note_halfper(input logic [KEY_IDX_W-1:0] idx);
        return NOTE_HALFPER[idx];
    endfunction

endpackage

// File: rtl/keyboard_arbiter_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// One pushbutton: 2-flop synchronizer followed by a consecutive-cycle debounce
// counter. The raw input is active low (pull-up); the output is active high.
// Ports:
//   clk     : clock
//   rst     : synchronous active-high reset
//   key_n   : raw pushbutton, active low, asynchronous to clk
//   pressed : debounced level, 1 = key held down
// -----------------------------------------------------------------------------
module key_debounce #(
    parameter int DEB_CYCLES = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic pressed
);

    localparam int CNT_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] deb_cnt;
    logic             level_now;

    assign level_now = ~sync_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            pressed <= 1'b0;
            deb_cnt <= '0;
        end else begin
            sync_p0 <= key_n;
            sync_p1 <= sync_p0;
            // Any cycle where the synchronized level agrees with the accepted
            // level restarts the count, so a glitch costs a full new window.
            if (level_now != pressed) begin
                if (deb_cnt == CNT_LAST) begin
                    pressed <= level_now;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/keyboard_arbiter.sv
// -----------------------------------------------------------------------------
// keyboard_arbiter
// Debounces NUM_KEYS note pushbuttons and lets one note at a time own a shared
// square-wave generator. The lowest pressed key wins from IDLE; the owner keeps
// the generator until it is released (no preemption), then a forced silent GAP
// separates it from the next note.
// Ports:
//   clockIn    : clock (25 kHz nominal)
//   reset      : synchronous active-high reset
//   pulsadores : raw pushbuttons, active low, bit i = note i
//   modulador  : unsigned offset added to the selected note's half-period
//   ondaOut    : square-wave output
//   noteActive : high while a note is playing
//   noteIdx    : index of the note owning the generator (held outside PLAY)
// -----------------------------------------------------------------------------
module keyboard_arbiter
    import keyboard_arbiter_pkg::*;
#(
    parameter int FrecIn     = 25000,
    parameter int NUM_KEYS   = 8,
    parameter int DEB_CYCLES = 250,
    parameter int GAP_CYCLES = 125
) (
    input  logic                 clockIn,
    input  logic                 reset,
    input  logic [NUM_KEYS-1:0]  pulsadores,
    input  logic [6:0]           modulador,
    output logic                 ondaOut,
    output logic                 noteActive,
    output logic [KEY_IDX_W-1:0] noteIdx
);

    localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    if (FrecIn < 1 || DEB_CYCLES < 1 || GAP_CYCLES < 1) begin : g_param_check
        $error("keyboard_arbiter: FrecIn, DEB_CYCLES and GAP_CYCLES must be positive");
    end

    state_t                 state;
    logic [NUM_KEYS-1:0]    deb;
    logic [HALFPER_W-1:0]   tone_cnt;
    logic [GAP_W-1:0]       gap_cnt;
    logic [HALFPER_W-1:0]   half_per;
    logic [KEY_IDX_W-1:0]   first_idx;
    logic                   any_key;
    logic                   owner_held;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        key_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clk     (clockIn),
            .rst     (reset),
            .key_n   (pulsadores[k]),
            .pressed (deb[k])
        );
    end

    // Lowest pressed index: scan downward so the smallest index is written last.
    always_comb begin
        first_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (deb[i]) begin
                first_idx = KEY_IDX_W'(i);
            end
        end
    end

    assign any_key    = |deb;
    assign owner_held = deb[noteIdx];

    // Max 47 + 127 = 174, fits in 8 bits. modulador is used live, so a change
    // affects the comparison in the same cycle.
    assign half_per = note_halfper(noteIdx) + HALFPER_W'(modulador);

    always_ff @(posedge clockIn) begin
        if (reset) begin
            state      <= ST_IDLE;
            ondaOut    <= 1'b0;
            noteActive <= 1'b0;
            noteIdx    <= '0;
            tone_cnt   <= '0;
            gap_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ondaOut <= 1'b0;
                    if (any_key) begin
                        noteIdx    <= first_idx;
                        tone_cnt   <= '0;
                        state      <= ST_PLAY;
                        noteActive <= 1'b1;
                    end
                end

                ST_PLAY: begin
                    if (!owner_held) begin
                        ondaOut    <= 1'b0;
                        tone_cnt   <= '0;
                        gap_cnt    <= '0;
                        state      <= ST_GAP;
                        noteActive <= 1'b0;
                    end else if (tone_cnt == half_per - 1'b1) begin
                        ondaOut  <= ~ondaOut;
                        tone_cnt <= '0;
                    end else begin
                        tone_cnt <= tone_cnt + 1'b1;
                    end
                end

                ST_GAP: begin
                    ondaOut <= 1'b0;
                    if (gap_cnt == GAP_LAST) begin
                        gap_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                default: begin
                    state      <= ST_IDLE;
                    ondaOut    <= 1'b0;
                    noteActive <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keyboard_arbiter.sv
// -----------------------------------------------------------------------------
// tb_keyboard_arbiter
// Directed-vector bench for keyboard_arbiter with default parameters.
// -----------------------------------------------------------------------------
module tb_keyboard_arbiter;

    localparam int NUM_KEYS   = 8;
    localparam int DEB_CYCLES = 250;
    localparam int GAP_CYCLES = 125;
    localparam int BUDGET     = 2000;

    logic                clockIn;
    logic                reset;
    logic [NUM_KEYS-1:0] pulsadores;
    logic [6:0]          modulador;
    logic                ondaOut;
    logic                noteActive;
    logic [2:0]          noteIdx;

    int n_checks;
    int n_fail;

    keyboard_arbiter #(
        .FrecIn     (25000),
        .NUM_KEYS   (NUM_KEYS),
        .DEB_CYCLES (DEB_CYCLES),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clockIn    (clockIn),
        .reset      (reset),
        .pulsadores (pulsadores),
        .modulador  (modulador),
        .ondaOut    (ondaOut),
        .noteActive (noteActive),
        .noteIdx    (noteIdx)
    );

    initial clockIn = 1'b0;
    always #5 clockIn = ~clockIn;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Negedges until noteActive equals lvl; -1 on timeout.
    task automatic wait_active(input logic lvl, output int n);
        n = 0;
        while (noteActive !== lvl) begin
            @(negedge clockIn);
            n++;
            if (n > BUDGET) begin
                n = -1;
                return;
            end
        end
    endtask

    // Negedges until ondaOut transitions to lvl; -1 on timeout.
    task automatic wait_edge(input logic lvl, output int n);
        logic prev;
        n    = 0;
        prev = ondaOut;
        forever begin
            @(negedge clockIn);
            n++;
            if (ondaOut === lvl && prev !== lvl) return;
            prev = ondaOut;
            if (n > BUDGET) begin
                n = -1;
                return;
            end
        end
    endtask

    // Rise-to-rise distance; ends just after a rising edge.
    task automatic measure_period(output int per);
        int n;
        wait_edge(1'b1, n);
        if (n < 0) begin
            per = -1;
            return;
        end
        wait_edge(1'b1, per);
    endtask

    task automatic release_and_settle();
        pulsadores = '1;
        repeat (DEB_CYCLES + GAP_CYCLES + 20) @(negedge clockIn);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time %0t, expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int per;
        int bad;
        int len;

        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b1;
        pulsadores = '1;
        modulador  = 7'd0;

        // Reset state
        repeat (3) @(negedge clockIn);
        check("reset_onda", ondaOut, 0);
        check("reset_active", noteActive, 0);
        check("reset_idx", noteIdx, 0);
        reset = 1'b0;
        repeat (5) @(negedge clockIn);

        // Key 5: latency DEB+3, first rise after 28, period 56
        pulsadores[5] = 1'b0;
        wait_active(1'b1, n);
        check("k5_latency", n, DEB_CYCLES + 3);
        check("k5_idx", noteIdx, 5);
        wait_edge(1'b1, n);
        check("k5_first_rise", n, 28);
        wait_edge(1'b1, per);
        check("k5_period", per, 56);
        pulsadores[5] = 1'b1;
        wait_active(1'b0, n);
        check("k5_release_latency", n, DEB_CYCLES + 3);
        check("k5_release_onda", ondaOut, 0);
        release_and_settle();

        // Keys 2 and 6 together: lowest wins, releasing 6 is ignored
        pulsadores[2] = 1'b0;
        pulsadores[6] = 1'b0;
        wait_active(1'b1, n);
        check("k26_latency", n, DEB_CYCLES + 3);
        check("k26_idx", noteIdx, 2);
        measure_period(per);
        check("k26_period", per, 74);
        pulsadores[6] = 1'b1;
        repeat (DEB_CYCLES + 50) @(negedge clockIn);
        check("k6_release_active", noteActive, 1);
        check("k6_release_idx", noteIdx, 2);
        measure_period(per);
        check("k6_release_period", per, 74);
        release_and_settle();

        // Key 3 playing, key 0 pressed (no preemption), key 3 released -> gap
        pulsadores[3] = 1'b0;
        wait_active(1'b1, n);
        check("k3_idx", noteIdx, 3);
        pulsadores[0] = 1'b0;
        repeat (DEB_CYCLES + 50) @(negedge clockIn);
        check("k0_nopreempt_idx", noteIdx, 3);
        check("k0_nopreempt_active", noteActive, 1);
        pulsadores[3] = 1'b1;
        wait_active(1'b0, n);
        check("k3_release_seen", (n > 0) ? 1 : 0, 1);
        len = 1;
        bad = (ondaOut !== 1'b0) ? 1 : 0;
        while (noteActive !== 1'b1 && len <= BUDGET) begin
            @(negedge clockIn);
            if (noteActive !== 1'b1) begin
                len++;
                if (ondaOut !== 1'b0) bad++;
            end
        end
        check("gap_len", len, GAP_CYCLES + 1);
        check("gap_onda_high", bad, 0);
        check("k0_idx", noteIdx, 0);
        wait_edge(1'b1, n);
        check("k0_first_rise", n, 47);
        wait_edge(1'b1, per);
        check("k0_period", per, 94);
        release_and_settle();

        // Key 7 with modulador=127, then switch to 0 mid-note
        modulador     = 7'd127;
        pulsadores[7] = 1'b0;
        wait_active(1'b1, n);
        check("k7_idx", noteIdx, 7);
        measure_period(per);
        check("k7_mod127_period", per, 300);
        modulador = 7'd0;
        wait_edge(1'b0, n);
        check("k7_mod0_fall", n, 23);
        wait_edge(1'b1, n);
        check("k7_mod0_rise", n, 23);
        wait_edge(1'b1, per);
        check("k7_mod0_period", per, 46);
        release_and_settle();

        // Key 1 bouncing with 10-cycle pulses for 200 cycles
        bad = 0;
        for (int c = 0; c < 200; c++) begin
            pulsadores[1] = ((c / 10) % 2 == 0) ? 1'b0 : 1'b1;
            @(negedge clockIn);
            if (noteActive !== 1'b0 || ondaOut !== 1'b0) bad++;
        end
        pulsadores[1] = 1'b1;
        repeat (DEB_CYCLES + 20) @(negedge clockIn);
        check("bounce_glitches", bad, 0);
        check("bounce_active", noteActive, 0);

        // Reset during PLAY, key 4 still held afterwards
        pulsadores[4] = 1'b0;
        wait_active(1'b1, n);
        check("k4_idx", noteIdx, 4);
        wait_edge(1'b1, n);
        check("k4_onda_high", ondaOut, 1);
        reset = 1'b1;
        @(negedge clockIn);
        check("rst_play_onda", ondaOut, 0);
        check("rst_play_active", noteActive, 0);
        check("rst_play_idx", noteIdx, 0);
        reset = 1'b0;
        wait_active(1'b1, n);
        check("rst_replay_latency", n, DEB_CYCLES + 3);
        check("rst_replay_idx", noteIdx, 4);
        release_and_settle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keyboard_arbiter.md
KEYBOARD_ARBITER -- requirements
Module: keyboard_arbiter

Interface
REQ-001 Parameter FrecIn, default 25000: input clock frequency in Hz.
REQ-002 Parameter NUM_KEYS, default 8: number of note pushbuttons.
REQ-003 Parameter DEB_CYCLES, default 250: stable-input cycles needed to accept a key change (10 ms at 25 kHz).
REQ-004 Parameter GAP_CYCLES, default 125: forced silence between consecutive notes (5 ms).
REQ-005 Port clockIn, input, 1: the only clock (25 kHz); all logic on its rising edge.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port pulsadores, input, NUM_KEYS: raw pushbuttons with pull-up, active low; asynchronous to clockIn; bit i selects note i.
REQ-008 Port modulador, input, 7: unsigned half-period offset added to the selected note.
REQ-009 Port ondaOut, output, 1: shared square-wave output.
REQ-010 Port noteActive, output, 1: high while in PLAY.
REQ-011 Port noteIdx, output, 3: index of the note that currently owns the generator.

Function
REQ-012 Each key passes through a 2-flop synchronizer, then is inverted to active-high.
REQ-013 Per-key debounce counter: the debounced level changes only after the synchronized level differs from it for DEB_CYCLES consecutive cycles; any glitch restarts the count.
REQ-014 Base half-period table in clock cycles, indices 0-7: 47, 42, 37, 35, 31, 28, 25, 23 (C4, D4, E4, F4, G4, A4, B4, C5 at 25 kHz).
REQ-015 halfPer = TABLE[noteIdx] + modulador, computed 8 bits wide, range 23-174; no overflow possible.
REQ-016 FSM states: IDLE, PLAY, GAP.
REQ-017 IDLE: if any debounced key is pressed, latch the lowest pressed index into noteIdx, clear the tone counter, and enter PLAY on the next cycle; otherwise stay in IDLE with ondaOut=0.
REQ-018 PLAY, counter: increments every cycle; when counter == halfPer-1, ondaOut toggles and counter returns to 0.
REQ-019 PLAY, modulador timing: sampled combinationally each cycle, so a change takes effect at the current comparison.
REQ-020 PLAY, first edge: the first ondaOut rise occurs halfPer cycles after PLAY is entered.
REQ-021 No preemption in PLAY: pressing other keys, including lower indices, does not change noteIdx.
REQ-022 PLAY exit: when the debounced owner key releases, ondaOut=0 and counter=0 on the next cycle and the FSM enters GAP; releasing non-owner keys has no effect.
REQ-023 GAP: ondaOut=0; after counting GAP_CYCLES cycles, enter IDLE; key presses during GAP are not lost because IDLE re-evaluates them.
REQ-024 noteActive = (state == PLAY), registered.
REQ-025 noteIdx holds its value outside PLAY.
REQ-026 Simultaneous debounced presses: the lowest index wins.
REQ-027 Owner release coinciding with a new press: go to GAP first; the new key is served after the gap.

Reset
REQ-028 While reset is high at a clock edge, the next state is: state=IDLE, ondaOut=0, noteActive=0, noteIdx=0, tone and gap counters=0, all debounced levels=released, debounce counters=0, synchronizers=released (1).
REQ-029 Reset asserted mid-note silences ondaOut on the next edge; after reset deasserts, a key still held needs a full sync + DEB_CYCLES before a new PLAY.

Structure
REQ-030 Shared package holds: FSM state encoding, NOTE_HALFPER table, and widths KEY_IDX_W=3 and HALFPER_W=8.
REQ-031 One sub-module, key_debounce (synchronizer + counter, 1 bit, parameter DEB_CYCLES), is instantiated NUM_KEYS times; FSM and tone counter live in the top.

Verification
REQ-032 Reset then key 5 held low: noteActive rises DEB_CYCLES+3 (±1) cycles after the press; with modulador=0, ondaOut has period 56 cycles.
REQ-033 Keys 2 and 6 pressed in the same cycle: noteIdx=2, ondaOut period 74 cycles; releasing key 6 has no effect.
REQ-034 Key 3 playing, key 0 pressed, then key 3 released: ondaOut=0 for exactly GAP_CYCLES+1 cycles, then key 0 plays with period 94 cycles.
REQ-035 Key 7 with modulador=127: half-period 150, period 300; switching modulador to 0 mid-note gives period 46 from the next toggle.
REQ-036 Key 1 bouncing with 10-cycle pulses for 200 cycles: no state change; reset during PLAY forces ondaOut=0 and noteActive=0 on the next edge.
